// File: rtl/cmd_frame_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the command frame controller.
package cmd_frame_ctrl_pkg;

    localparam int unsigned OP_W = 8;

    localparam logic [OP_W-1:0] OP_WR      = 8'hAA;
    localparam logic [OP_W-1:0] OP_RD      = 8'hBB;
    localparam logic [OP_W-1:0] OP_ALU_OP  = 8'hCC;
    localparam logic [OP_W-1:0] OP_ALU_NOP = 8'hDD;
    localparam logic [OP_W-1:0] OP_BURST   = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        BR_ADDR,
        BR_CNT,
        OP_A,
        OP_B,
        OP_FUN,
        RD_REQ,
        RD_WAIT,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    // States that are still collecting frame bytes (timeout armed, bytes accepted).
    function automatic logic is_collect(input state_t s);
        return (s inside {WR_ADDR, WR_DATA, RD_ADDR, BR_ADDR, BR_CNT, OP_A, OP_B, OP_FUN});
    endfunction

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// Bundles RX, register-file, ALU and TX FIFO signals of the command frame controller.
interface cmd_frame_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FUN_W  = 4
);
    logic [DATA_W-1:0]   i_rx_data;
    logic                i_rx_valid;
    logic [DATA_W-1:0]   i_rf_rd_data;
    logic                i_rf_rd_valid;
    logic [2*DATA_W-1:0] i_alu_out;
    logic                i_alu_valid;
    logic                i_tx_full;

    logic [ADDR_W-1:0]   o_rf_addr;
    logic [DATA_W-1:0]   o_rf_wr_data;
    logic                o_rf_wr_en;
    logic                o_rf_rd_en;
    logic [FUN_W-1:0]    o_alu_fun;
    logic                o_alu_en;
    logic                o_alu_clk_en;
    logic                o_clk_div_en;
    logic [DATA_W-1:0]   o_tx_data;
    logic                o_tx_valid;
    logic                o_busy;
    logic                o_cmd_err;
    logic                o_timeout;

    modport master (
        input  i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
               i_alu_out, i_alu_valid, i_tx_full,
        output o_rf_addr, o_rf_wr_data, o_rf_wr_en, o_rf_rd_en, o_alu_fun,
               o_alu_en, o_alu_clk_en, o_clk_div_en, o_tx_data, o_tx_valid,
               o_busy, o_cmd_err, o_timeout
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
               i_alu_out, i_alu_valid, i_tx_full,
        input  o_rf_addr, o_rf_wr_data, o_rf_wr_en, o_rf_rd_en, o_alu_fun,
               o_alu_en, o_alu_clk_en, o_clk_div_en, o_tx_data, o_tx_valid,
               o_busy, o_cmd_err, o_timeout
    );

endinterface

// File: rtl/cmd_frame_ctrl_frame_timer.sv
// Inter-byte timeout counter: clears on every byte, counts while enabled,
// flags terminal count at TIMEOUT_CYC-1.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);
    localparam int unsigned      CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tc_c = i_en && (cnt_q == TC_VAL);

    // Hold at terminal count; the controller leaves the collecting state on it.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (!o_tc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Byte-frame command parser driving register-file and ALU handshakes and
// pushing response bytes into the TX FIFO.
module cmd_frame_ctrl
    import cmd_frame_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FUN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             i_clk,
    input  logic             i_arst,
    cmd_frame_ctrl_if.master bus
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] rf_addr_q,    rf_addr_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
    logic              rf_wr_en_q,   rf_wr_en_d;
    logic              rf_rd_en_q,   rf_rd_en_d;
    logic [FUN_W-1:0]  alu_fun_q,    alu_fun_d;
    logic              alu_en_q,     alu_en_d;
    logic              alu_clk_en_q, alu_clk_en_d;
    logic              clk_div_en_q, clk_div_en_d;
    logic [DATA_W-1:0] tx_data_q,    tx_data_d;
    logic              tx_pend_q,    tx_pend_d;
    logic              busy_q,       busy_d;
    logic              cmd_err_q,    cmd_err_d;
    logic              timeout_q,    timeout_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] cnt_q,        cnt_d;
    logic [DATA_W-1:0] res_hi_q,     res_hi_d;

    logic [DATA_W-1:0] rx;
    logic              rx_v;
    logic              collect;
    logic              tc;
    logic              tx_acc;
    logic              last_rd;
    logic              op_known;
    state_t            op_state;

    assign rx      = bus.i_rx_data;
    assign rx_v    = bus.i_rx_valid;
    assign collect = is_collect(state_q);
    assign tx_acc  = tx_pend_q & ~bus.i_tx_full;
    assign last_rd = (cnt_q == DATA_W'(1));

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_timer (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_clr  (rx_v),
        .i_en   (collect),
        .o_tc_c (tc)
    );

    // Opcode decode of the first frame byte.
    always_comb begin
        op_known = 1'b1;
        op_state = IDLE;
        case (rx)
            DATA_W'(OP_WR):      op_state = WR_ADDR;
            DATA_W'(OP_RD):      op_state = RD_ADDR;
            DATA_W'(OP_ALU_OP):  op_state = OP_A;
            DATA_W'(OP_ALU_NOP): op_state = OP_FUN;
            DATA_W'(OP_BURST):   op_state = BR_ADDR;
            default:             op_known = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a byte in a collecting state beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rx_v && op_known) state_d = op_state;
            WR_ADDR:  if (rx_v) state_d = WR_DATA;
            WR_DATA:  if (rx_v) state_d = IDLE;
            RD_ADDR:  if (rx_v) state_d = RD_WAIT;
            BR_ADDR:  if (rx_v) state_d = BR_CNT;
            BR_CNT:   if (rx_v) state_d = (rx == '0) ? IDLE : RD_WAIT;
            OP_A:     if (rx_v) state_d = OP_B;
            OP_B:     if (rx_v) state_d = OP_FUN;
            OP_FUN:   if (rx_v) state_d = ALU_WAIT;
            RD_WAIT:  if (bus.i_rf_rd_valid) state_d = RD_REQ;
            RD_REQ:   if (tx_acc) state_d = last_rd ? IDLE : RD_WAIT;
            ALU_WAIT: if (bus.i_alu_valid) state_d = TX_LO;
            TX_LO:    if (tx_acc) state_d = TX_HI;
            TX_HI:    if (tx_acc) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (collect && !rx_v && tc) begin
            state_d = IDLE;
        end
    end

    // Registered outputs and frame datapath.
    always_comb begin
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        alu_clk_en_d = alu_clk_en_q;
        clk_div_en_d = 1'b1;
        tx_data_d    = tx_data_q;
        tx_pend_d    = tx_pend_q & ~tx_acc;
        busy_d       = (state_d != IDLE);
        cmd_err_d    = 1'b0;
        timeout_d    = 1'b0;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        res_hi_d     = res_hi_q;

        case (state_q)
            IDLE: begin
                if (rx_v && !op_known) cmd_err_d = 1'b1;
            end
            WR_ADDR: begin
                if (rx_v) addr_d = rx[ADDR_W-1:0];
            end
            WR_DATA: begin
                if (rx_v) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = addr_q;
                    rf_wr_data_d = rx;
                end
            end
            RD_ADDR: begin
                if (rx_v) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = rx[ADDR_W-1:0];
                    addr_d     = rx[ADDR_W-1:0];
                    cnt_d      = DATA_W'(1);
                end
            end
            BR_ADDR: begin
                if (rx_v) addr_d = rx[ADDR_W-1:0];
            end
            BR_CNT: begin
                if (rx_v && (rx != '0)) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = addr_q;
                    cnt_d      = rx;
                end
            end
            OP_A: begin
                if (rx_v) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_W'(0);
                    rf_wr_data_d = rx;
                end
            end
            OP_B: begin
                if (rx_v) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_W'(1);
                    rf_wr_data_d = rx;
                end
            end
            OP_FUN: begin
                if (rx_v) begin
                    alu_fun_d    = rx[FUN_W-1:0];
                    alu_en_d     = 1'b1;
                    alu_clk_en_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (bus.i_rf_rd_valid) begin
                    tx_data_d = bus.i_rf_rd_data;
                    tx_pend_d = 1'b1;
                end
            end
            RD_REQ: begin
                // Next burst read only after the previous byte left for the FIFO.
                if (tx_acc) begin
                    cnt_d = cnt_q - DATA_W'(1);
                    if (!last_rd) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        rf_addr_d  = addr_q + ADDR_W'(1);
                        rf_rd_en_d = 1'b1;
                    end
                end
            end
            ALU_WAIT: begin
                if (bus.i_alu_valid) begin
                    alu_clk_en_d = 1'b0;
                    tx_data_d    = bus.i_alu_out[DATA_W-1:0];
                    res_hi_d     = bus.i_alu_out[DATA_W +: DATA_W];
                    tx_pend_d    = 1'b1;
                end
            end
            TX_LO: begin
                if (tx_acc) begin
                    tx_data_d = res_hi_q;
                    tx_pend_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (rx_v && !collect && (state_q != IDLE)) cmd_err_d = 1'b1;
        if (collect && !rx_v && tc) timeout_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            alu_clk_en_q <= 1'b0;
            clk_div_en_q <= 1'b0;
            tx_data_q    <= '0;
            tx_pend_q    <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            res_hi_q     <= '0;
        end else begin
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            alu_clk_en_q <= alu_clk_en_d;
            clk_div_en_q <= clk_div_en_d;
            tx_data_q    <= tx_data_d;
            tx_pend_q    <= tx_pend_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
            timeout_q    <= timeout_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            res_hi_q     <= res_hi_d;
        end
    end

    assign bus.o_rf_addr    = rf_addr_q;
    assign bus.o_rf_wr_data = rf_wr_data_q;
    assign bus.o_rf_wr_en   = rf_wr_en_q;
    assign bus.o_rf_rd_en   = rf_rd_en_q;
    assign bus.o_alu_fun    = alu_fun_q;
    assign bus.o_alu_en     = alu_en_q;
    assign bus.o_alu_clk_en = alu_clk_en_q;
    assign bus.o_clk_div_en = clk_div_en_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_valid   = tx_acc;
    assign bus.o_busy       = busy_q;
    assign bus.o_cmd_err    = cmd_err_q;
    assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl with simple register-file and ALU responders.
module tb_cmd_frame_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FUN_W  = 4;
    localparam int unsigned TO_CYC = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_frame_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) bus ();

    cmd_frame_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .i_clk  (clk),
        .i_arst (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_fun[$];
    logic [7:0]  shadow[16];
    logic [7:0]  rf_mem[16];
    logic [15:0] alu_res;
    int          alu_cnt;
    int          err_seen = 0, err_exp = 0;
    int          to_seen = 0, to_exp = 0;
    int          tx_seen = 0;
    logic        rd_pending;
    logic [11:0] e_wr;
    logic [3:0]  e_rd;
    logic [7:0]  e_tx;
    logic [3:0]  e_fun;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: 1-cycle read latency, reloads a known pattern on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'(8'h40 + i);
            bus.i_rf_rd_valid <= 1'b0;
            bus.i_rf_rd_data  <= '0;
        end else begin
            bus.i_rf_rd_valid <= bus.o_rf_rd_en;
            bus.i_rf_rd_data  <= rf_mem[bus.o_rf_addr];
            if (bus.o_rf_wr_en) rf_mem[bus.o_rf_addr] <= bus.o_rf_wr_data;
        end
    end

    // ALU: result valid a fixed number of cycles after start.
    always @(posedge clk) begin
        bus.i_alu_valid <= 1'b0;
        if (rst) begin
            alu_cnt <= 0;
        end else if (bus.o_alu_en) begin
            alu_cnt <= 6;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) bus.i_alu_valid <= 1'b1;
        end
    end
    assign bus.i_alu_out = alu_res;

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            rd_pending = 1'b0;
        end else begin
            if (bus.o_rf_wr_en) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    e_wr = exp_wr.pop_front();
                    check("rf_write", {bus.o_rf_addr, bus.o_rf_wr_data}, e_wr);
                end
            end
            if (bus.o_rf_rd_en) begin
                check("rd_before_tx", rd_pending, 0);
                rd_pending = 1'b1;
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e_rd = exp_rd.pop_front();
                    check("rf_read_addr", bus.o_rf_addr, e_rd);
                end
            end
            if (bus.i_tx_full) check("winc_while_full", bus.o_tx_valid, 0);
            if (bus.o_tx_valid) begin
                tx_seen++;
                rd_pending = 1'b0;
                if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                else begin
                    e_tx = exp_tx.pop_front();
                    check("tx_byte", bus.o_tx_data, e_tx);
                end
            end
            if (bus.o_alu_en) begin
                check("alu_clk_en_at_start", bus.o_alu_clk_en, 1);
                if (exp_fun.size() == 0) check("alu_unexpected", 1, 0);
                else begin
                    e_fun = exp_fun.pop_front();
                    check("alu_fun", bus.o_alu_fun, e_fun);
                end
            end
            if (bus.o_cmd_err) err_seen++;
            if (bus.o_timeout) to_seen++;
        end
    end

    task automatic init_shadow();
        for (int i = 0; i < 16; i++) shadow[i] = 8'(8'h40 + i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.o_busy || (exp_tx.size() + exp_rd.size() + exp_wr.size() + exp_fun.size()) != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_budget"}, (n < budget), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.o_rf_addr, bus.o_rf_wr_data, bus.o_rf_wr_en, bus.o_rf_rd_en,
                    bus.o_alu_fun, bus.o_alu_en, bus.o_alu_clk_en, bus.o_clk_div_en,
                    bus.o_tx_data, bus.o_tx_valid, bus.o_busy, bus.o_cmd_err,
                    bus.o_timeout}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int tx0;
        logic [3:0] a;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_full  = 1'b0;
        alu_res        = '0;
        init_shadow();

        // Reset state and clock-divider enable.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("clk_div_en_before_edge", bus.o_clk_div_en, 0);
        @(negedge clk);
        check("clk_div_en_after_release", bus.o_clk_div_en, 1);

        // Single write.
        exp_wr.push_back({4'h5, 8'h3C});
        shadow[5] = 8'h3C;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_idle("wr", 40);

        // Single read.
        exp_rd.push_back(4'h5);
        exp_tx.push_back(shadow[5]);
        send_byte(8'hBB); send_byte(8'h05);
        wait_idle("rd", 40);
        check("rd_busy_low", bus.o_busy, 0);

        // ALU with operands.
        exp_wr.push_back({4'h0, 8'h0A}); shadow[0] = 8'h0A;
        exp_wr.push_back({4'h1, 8'h03}); shadow[1] = 8'h03;
        exp_fun.push_back(4'h2);
        alu_res = 16'h001E;
        exp_tx.push_back(8'h1E);
        exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h02);
        wait_idle("alu_op", 60);
        check("alu_clk_en_dropped", bus.o_alu_clk_en, 0);

        // Burst with address wrap and FIFO back-pressure.
        for (int i = 0; i < 4; i++) begin
            a = 4'(14 + i);
            exp_rd.push_back(a);
            exp_tx.push_back(shadow[a]);
        end
        tx0 = tx_seen;
        send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h04);
        n = 0;
        while (tx_seen == tx0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("burst_first_tx_in_budget", (n < 50), 1);
        @(posedge clk);
        #1 bus.i_tx_full = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.i_tx_full = 1'b0;
        wait_idle("burst", 80);
        check("burst_tx_count", tx_seen - tx0, 4);

        // Zero-length burst.
        send_byte(8'hEE); send_byte(8'h03); send_byte(8'h00);
        repeat (2) @(negedge clk);
        check("burst_cnt0_idle", bus.o_busy, 0);

        // Unknown opcode.
        err_exp++;
        send_byte(8'h77);
        repeat (2) @(negedge clk);
        check("unknown_opcode_err", err_seen, err_exp);
        check("unknown_opcode_idle", bus.o_busy, 0);

        // Byte arriving on the timeout terminal-count cycle is accepted.
        exp_wr.push_back({4'h7, 8'h5A});
        shadow[7] = 8'h5A;
        send_byte(8'hAA); send_byte(8'h07);
        repeat (TO_CYC - 2) @(posedge clk);
        send_byte(8'h5A);
        wait_idle("byte_wins", 40);
        check("byte_wins_no_timeout", to_seen, to_exp);

        // Timeout aborts a partial write.
        to_exp++;
        send_byte(8'hAA); send_byte(8'h05);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_timeout && n < 4 * TO_CYC);
        check("timeout_cycle", n, TO_CYC + 1);
        @(negedge clk);
        check("timeout_count", to_seen, to_exp);
        check("timeout_idle", bus.o_busy, 0);

        // ALU without operands plus an overrun byte during the wait.
        exp_fun.push_back(4'h5);
        alu_res = 16'h1234;
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        err_exp++;
        send_byte(8'hDD); send_byte(8'h05); send_byte(8'h55);
        wait_idle("alu_nop", 60);
        check("overrun_err", err_seen, err_exp);

        // Reset in the middle of a frame.
        send_byte(8'hAA); send_byte(8'h05);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("midframe_reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        init_shadow();
        repeat (3) @(negedge clk);
        check("midframe_reset_idle", bus.o_busy, 0);

        // Reset while a TX byte is held back by a full FIFO discards it.
        bus.i_tx_full = 1'b1;
        exp_rd.push_back(4'h5);
        send_byte(8'hBB); send_byte(8'h05);
        repeat (5) @(negedge clk);
        check("held_byte_busy", bus.o_busy, 1);
        tx0 = tx_seen;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.i_tx_full = 1'b0;
        init_shadow();
        repeat (10) @(negedge clk);
        check("held_byte_discarded", tx_seen - tx0, 0);
        check("held_byte_idle", bus.o_busy, 0);

        check("queues_drained", exp_tx.size() + exp_rd.size() + exp_wr.size() + exp_fun.size(), 0);
        check("err_total", err_seen, err_exp);
        check("timeout_total", to_seen, to_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
